// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit (AND/OR/XOR/NOR)
// with valid/ready handshakes on both sides, a pass-through sideband tag
// and a saturating count of completed output handshakes.
// Optional feature macro: LOGIC_FLAGS_EN (adds registered zero/parity flags).
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_parity,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  // Stage 1: captured operands
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [1:0]       r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 2: registered result
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic [TAG_W-1:0] r_s2_tag;

  logic [CNT_W-1:0] r_count;

  logic             w_s2_ready;
  logic             w_s1_load;
  logic             w_s1_adv;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_result;

  // Ready chain: a stage can take data when empty or when it is emptying this cycle
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_s1_load  = in_valid && in_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  // Bitwise operation on the stage-1 operands; NOR covers the full width
  always_comb begin
    w_result = '0;
    case (r_s1_op)
      OP_AND:  w_result = r_s1_a & r_s1_b;
      OP_OR:   w_result = r_s1_a | r_s1_b;
      OP_XOR:  w_result = r_s1_a ^ r_s1_b;
      default: w_result = ~(r_s1_a | r_s1_b);
    endcase
  end

  // Stage 1 valid: set on accept, cleared when the beat moves on with no replacement
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 1 payload capture on input handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_op  <= '0;
      r_s1_tag <= '0;
    end else if (w_s1_load) begin
      r_s1_a   <= in_a;
      r_s1_b   <= in_b;
      r_s1_op  <= in_op;
      r_s1_tag <= in_tag;
    end
  end

  // Stage 2 valid follows stage 1 whenever stage 2 is free to update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
    end
  end

  // Stage 2 payload: loads only when a beat advances, so it holds under backpressure
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_data <= '0;
      r_s2_tag  <= '0;
    end else if (w_s1_adv) begin
      r_s2_data <= w_result;
      r_s2_tag  <= r_s1_tag;
    end
  end

`ifdef LOGIC_FLAGS_EN
  logic r_s2_zero;
  logic r_s2_parity;

  // Result flags registered alongside the stage-2 data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_zero   <= 1'b0;
      r_s2_parity <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_zero   <= (w_result == '0);
      r_s2_parity <= ^w_result;
    end
  end

  assign out_zero   = r_s2_zero;
  assign out_parity = r_s2_parity;
`else
  assign out_zero   = 1'b0;
  assign out_parity = 1'b0;
`endif

  // Completed-operation counter: clear wins, otherwise saturating increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (w_out_fire && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_tag   = r_s2_tag;
  assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=32, TAG_W=5, CNT_W=16).
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_logic_unit_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        out_parity;
  logic        cnt_clr;
  logic [15:0] op_count;

  int tests = 0;
  int fails = 0;
  int accepts = 0;
  int received = 0;
  logic        last_acc;
  logic [31:0] cur_exp;
  logic [36:0] exp_q[$];

  logic_unit_pipe #(.WIDTH(32), .TAG_W(5), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_zero(out_zero), .out_parity(out_parity),
    .cnt_clr(cnt_clr), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [36:0] obs, input logic [36:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [4:0] tag, input logic [31:0] expv);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_tag = tag;
    cur_exp = expv;
  endtask

  // One clock: log handshakes against the scoreboard, then advance to the next falling edge
  task automatic tick();
    logic [36:0] e;
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      accepts++;
      exp_q.push_back({in_tag, cur_exp});
    end
    if (out_valid && out_ready) begin
      received++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {5'd0, out_data}, 37'h0);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] beat tag=%0d data=%08h expected tag=%0d data=%08h",
                 out_tag, out_data, e[36:32], e[31:0]);
        check("beat_data_tag", {out_tag, out_data}, e);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int acc0;
    int rcv0;
    int j;
    logic [31:0] held;
    logic [31:0] bp_a [0:2];
    logic [31:0] bp_b [0:2];
    logic [1:0]  bp_op[0:2];
    logic [31:0] bp_e [0:2];

    bp_a[0] = 32'hFFFF_FFFE; bp_b[0] = 32'h0000_0000; bp_op[0] = 2'b11; bp_e[0] = 32'h0000_0001;
    bp_a[1] = 32'hAAAA_AAAA; bp_b[1] = 32'h5555_5555; bp_op[1] = 2'b10; bp_e[1] = 32'hFFFF_FFFF;
    bp_a[2] = 32'h1234_5678; bp_b[2] = 32'h0F0F_0F0F; bp_op[2] = 2'b00; bp_e[2] = 32'h0204_0608;

    // ---- reset state
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0; cur_exp = '0;
    #1;
    check("rst_out_valid", {36'd0, out_valid}, 37'd0);
    check("rst_op_count", {21'd0, op_count}, 37'd0);
    check("rst_out_data", {5'd0, out_data}, 37'd0);
    check("rst_out_tag", {32'd0, out_tag}, 37'd0);
    check("rst_flags", {35'd0, out_zero, out_parity}, 37'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", {36'd0, in_ready}, 37'd1);

    // ---- OR basic with latency check
    out_ready = 1'b1;
    drive(32'hF0F0_0000, 32'h0000_0F0F, 2'b01, 5'd3, 32'hF0F0_0F0F);
    tick();
    in_valid = 1'b0;
    #1;
    check("lat_after_1_edge", {36'd0, out_valid}, 37'd0);
    tick();
    #1;
    check("lat_after_2_edges", {36'd0, out_valid}, 37'd1);
    check("or_basic", {out_tag, out_data}, {5'd3, 32'hF0F0_0F0F});
    tick();
    #1;
    check("or_count", {21'd0, op_count}, 37'd1);
    check("or_drained", {36'd0, out_valid}, 37'd0);

    // ---- all four ops, back to back
    drive(32'hFFFF_0000, 32'hFF00_FF00, 2'b00, 5'd4, 32'hFF00_0000); tick();
    drive(32'hFFFF_0000, 32'hFF00_FF00, 2'b01, 5'd5, 32'hFFFF_FF00); tick();
    drive(32'hFFFF_0000, 32'hFF00_FF00, 2'b10, 5'd6, 32'h00FF_FF00); tick();
    drive(32'hFFFF_0000, 32'hFF00_FF00, 2'b11, 5'd7, 32'h0000_00FF); tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("allops_drained", exp_q.size(), 37'd0);

    // ---- 8-beat streaming: results must come out in exactly 10 cycles
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    rcv0 = received;
    for (int i = 0; i < 8; i++) begin
      drive(32'h1111_1111 * i, 32'h0, 2'b01, i[4:0], 32'h1111_1111 * i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("stream_beats", received - rcv0, 37'd8);
    #1;
    check("stream_count", {21'd0, op_count}, 37'd8);

    // ---- backpressure: 5 stalled cycles, 2 accepts, stable output
    out_ready = 1'b0;
    acc0 = accepts; rcv0 = received; j = 0;
    for (int c = 0; c < 5; c++) begin
      drive(bp_a[j], bp_b[j], bp_op[j], 5'd20 + j[4:0], bp_e[j]);
      tick();
      if (last_acc) j++;
      #1;
      if (c == 1) held = out_data;
      if (c >= 2) check("bp_hold_data", {5'd0, out_data}, {5'd0, held});
    end
    check("bp_accepts", accepts - acc0, 37'd2);
    check("bp_in_ready_low", {36'd0, in_ready}, 37'd0);
    check("bp_head", {out_tag, out_data}, {5'd20, 32'h0000_0001});
`ifdef LOGIC_FLAGS_EN
    check("bp_flags", {35'd0, out_zero, out_parity}, 37'b01);
`else
    check("bp_flags", {35'd0, out_zero, out_parity}, 37'b00);
`endif
    // release with both stages full while a third beat is waiting
    out_ready = 1'b1;
    drive(bp_a[j], bp_b[j], bp_op[j], 5'd20 + j[4:0], bp_e[j]);
    tick();
    check("bp_release_accept", {36'd0, last_acc}, 37'd1);
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_all_received", received - rcv0, 37'd3);
    check("bp_queue_empty", exp_q.size(), 37'd0);

    // ---- flags on an all-zero XOR result
    drive(32'h1234_5678, 32'h1234_5678, 2'b10, 5'd9, 32'h0000_0000);
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    check("flag_beat_valid", {36'd0, out_valid}, 37'd1);
`ifdef LOGIC_FLAGS_EN
    check("flags_xor_zero", {35'd0, out_zero, out_parity}, 37'b10);
`else
    check("flags_tied_off", {35'd0, out_zero, out_parity}, 37'b00);
`endif
    repeat (2) tick();
    check("flag_queue_empty", exp_q.size(), 37'd0);

    // ---- counter preload and saturation (raw clocking, scoreboard not used)
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_a = 32'h5; in_b = 32'h0; in_op = 2'b01; in_tag = 5'd1;
    repeat (65537) @(posedge clock);
    @(negedge clock); #1;
    check("cnt_preload", {21'd0, op_count}, 37'h0FFFF);
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    check("cnt_saturate", {21'd0, op_count}, 37'h0FFFF);
    check("cnt_handshaking", {35'd0, out_valid, out_ready}, 37'b11);
    cnt_clr = 1'b1;
    @(posedge clock); @(negedge clock); #1;
    check("cnt_clr_priority", {21'd0, op_count}, 37'd0);
    cnt_clr = 1'b0;
    @(posedge clock); @(negedge clock); #1;
    check("cnt_after_clr", {21'd0, op_count}, 37'd1);

    // ---- reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);     // let the stream settle into the stalled pipe
    @(negedge clock); #1;
    check("mid_pipe_full", {35'd0, out_valid, in_ready}, 37'b10);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {36'd0, out_valid}, 37'd0);
    check("mid_rst_op_count", {21'd0, op_count}, 37'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rel_in_ready", {36'd0, in_ready}, 37'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock); #1;
      check("mid_no_ghost_beat", {36'd0, out_valid}, 37'd0);
    end
    check("mid_count_still_0", {21'd0, op_count}, 37'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
